// File: rtl/hdc_pkg.sv
//============================================================================
// Module  : hdc_pkg
// Purpose : Shared types and helpers for the hyperdimensional associative
//           search datapath: hypervector type, scan FSM states and
//           derived-width helper functions.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef DIM
`define DIM 256
`endif

package hdc_pkg;

    typedef logic [`DIM-1:0] hv_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of SEG_W-wide segments in one hypervector.
    function automatic int calc_nseg(input int dim, input int seg_w);
        return dim / seg_w;
    endfunction

    // Bits needed to hold a Hamming distance in the range 0..dim.
    function automatic int calc_dist_w(input int dim);
        return $clog2(dim + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_search_popcount.sv
//============================================================================
// Module  : popcount_seg
// Purpose : Combinational population count of one SEG_W-bit segment.
// Ports   : i_bits   [SEG_W-1:0]            bits to count
//           o_count  [$clog2(SEG_W+1)-1:0]  number of set bits
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module popcount_seg #(
    parameter int SEG_W = 64,
    parameter int PC_W  = $clog2(SEG_W + 1)
) (
    input  logic [SEG_W-1:0] i_bits,
    output logic [PC_W-1:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < SEG_W; i++) begin
            o_count = o_count + PC_W'(i_bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/assoc_search.sv
//============================================================================
// Module  : assoc_search
// Purpose : Associative memory holding NCLASS class hypervectors. For each
//           accepted query it scans every class SEG_W bits per cycle and
//           returns the class index with minimum Hamming distance (ties keep
//           the lower index) together with that distance.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           cls_we/cls_waddr/cls_wdata  class-memory write (IDLE only)
//           q_valid/q_ready/q_hv     query handshake and hypervector
//           res_valid/res_ready      result handshake
//           res_class/res_dist       winning class and its distance
//           busy                     high while scanning or holding a result
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module assoc_search
    import hdc_pkg::*;
#(
    parameter int NCLASS = 10,
    parameter int SEG_W  = 64,
    parameter int CLS_W  = $clog2(NCLASS),
    parameter int DIST_W = calc_dist_w(`DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cls_we,
    input  logic [CLS_W-1:0]  cls_waddr,
    input  hv_t               cls_wdata,
    input  logic              q_valid,
    output logic              q_ready,
    input  hv_t               q_hv,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CLS_W-1:0]  res_class,
    output logic [DIST_W-1:0] res_dist,
    output logic              busy
);

    localparam int c_nseg   = calc_nseg(`DIM, SEG_W);
    localparam int c_seg_cw = (c_nseg > 1) ? $clog2(c_nseg) : 1;
    localparam int c_pc_w   = $clog2(SEG_W + 1);

    generate
        if ((`DIM % SEG_W) != 0) begin : g_dim_check
            $error("assoc_search: DIM must be a multiple of SEG_W");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next_state;

    hv_t                 r_q;
    hv_t                 r_mem [NCLASS];
    logic [c_seg_cw-1:0] r_seg;
    logic [CLS_W-1:0]    r_cls;
    logic [DIST_W-1:0]   r_acc;
    logic [CLS_W-1:0]    r_best_cls;
    logic [DIST_W-1:0]   r_best_dist;

    logic [SEG_W-1:0]    w_q_seg;
    logic [SEG_W-1:0]    w_c_seg;
    logic [c_pc_w-1:0]   w_pc;
    logic [DIST_W-1:0]   w_d;
    logic                w_last_seg;
    logic                w_last_cls;
    logic                w_waddr_ok;

    // Segment mux: the {class, segment} counters address both the latched
    // query and the class memory.
    assign w_q_seg = r_q[r_seg*SEG_W +: SEG_W];
    assign w_c_seg = r_mem[r_cls][r_seg*SEG_W +: SEG_W];

    popcount_seg #(
        .SEG_W (SEG_W),
        .PC_W  (c_pc_w)
    ) u_popcount (
        .i_bits  (w_q_seg ^ w_c_seg),
        .o_count (w_pc)
    );

    assign w_d        = r_acc + DIST_W'(w_pc);
    assign w_last_seg = (r_seg == c_seg_cw'(c_nseg - 1));
    assign w_last_cls = (r_cls == CLS_W'(NCLASS - 1));
    assign w_waddr_ok = (32'(cls_waddr) < NCLASS);

    assign res_class  = r_best_cls;
    assign res_dist   = r_best_dist;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        q_ready      = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                q_ready = 1'b1;
                if (q_valid) begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (w_last_seg && w_last_cls) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: class memory, query latch, scan counters, best tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_seg       <= '0;
            r_cls       <= '0;
            r_acc       <= '0;
            r_best_cls  <= '0;
            r_best_dist <= '0;
            for (int i = 0; i < NCLASS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    // A write coinciding with query accept lands at this edge,
                    // before the first segment read of the scan.
                    if (cls_we && w_waddr_ok) begin
                        r_mem[cls_waddr] <= cls_wdata;
                    end
                    if (q_valid) begin
                        r_q   <= q_hv;
                        r_seg <= '0;
                        r_cls <= '0;
                        r_acc <= '0;
                    end
                end
                SCAN: begin
                    if (w_last_seg) begin
                        // Class 0 seeds the tracker; strict compare keeps the
                        // lower index on ties.
                        if ((r_cls == '0) || (w_d < r_best_dist)) begin
                            r_best_cls  <= r_cls;
                            r_best_dist <= w_d;
                        end
                        r_acc <= '0;
                        r_seg <= '0;
                        r_cls <= w_last_cls ? '0 : r_cls + 1'b1;
                    end else begin
                        r_acc <= w_d;
                        r_seg <= r_seg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
